// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fault encodings, fetch FSM states and the NOP word
package fetch_pkg;
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_RANGE    = 2'b10;
    typedef enum logic {FETCH_RUN, FETCH_FAULT} fetch_state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_pc_check.sv
// fetch_pc_check: flags a fetch address that is misaligned or past the last legal word
module fetch_pc_check import fetch_pkg::*; #(
    parameter int Width     = 32,
    parameter int AddrLimit = 512
) (
    input  logic [Width-1:0] addr,
    output logic             misaligned,
    output logic             out_of_range
);
    localparam logic [Width-1:0] MaxAddr = Width'(AddrLimit - 4);
    assign misaligned   = |addr[1:0];
    assign out_of_range = addr > MaxAddr;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with a one-entry valid/ready output stage and sticky fetch faults
module fetch_unit import fetch_pkg::*; #(
    parameter int               Width     = 32,
    parameter logic [Width-1:0] ResetPC   = '0,
    parameter int               AddrLimit = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [Width-1:0] imem_addr,
    input  logic [Width-1:0] imem_rd,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_instr,
    output logic [Width-1:0] out_pc,
    output logic             fault,
    output logic [1:0]       fault_cause
);
    logic [Width-1:0] pc_q, pc_d, instr_q, instr_d, opc_q, opc_d;
    logic             valid_q, valid_d, stage_free;
    logic [1:0]       cause_q, cause_d;
    fetch_state_t     state_q, state_d;
    logic             pc_mis, pc_oor, rt_mis, rt_oor;

    fetch_pc_check #(.Width(Width), .AddrLimit(AddrLimit)) u_pc_chk (
        .addr(pc_q), .misaligned(pc_mis), .out_of_range(pc_oor)
    );
    fetch_pc_check #(.Width(Width), .AddrLimit(AddrLimit)) u_rt_chk (
        .addr(redirect_target), .misaligned(rt_mis), .out_of_range(rt_oor)
    );

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        valid_d    = valid_q;
        cause_d    = cause_q;
        state_d    = state_q;
        stage_free = !valid_q | out_ready;
        if (state_q == FETCH_FAULT) begin
            valid_d = 1'b0;
        end else if (redirect_valid) begin
            // a redirect squashes the held word even when decode takes it this cycle
            valid_d = 1'b0;
            if (rt_mis | rt_oor) begin
                state_d = FETCH_FAULT;
                cause_d = rt_mis ? FC_MISALIGN : FC_RANGE;
            end else begin
                pc_d = redirect_target;
            end
        end else if (en & stage_free) begin
            if (pc_mis | pc_oor) begin
                state_d = FETCH_FAULT;
                cause_d = pc_mis ? FC_MISALIGN : FC_RANGE;
                valid_d = 1'b0;
            end else begin
                instr_d = imem_rd;
                opc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + Width'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= ResetPC;
            instr_q <= '0;
            opc_q   <= '0;
            valid_q <= 1'b0;
            cause_q <= FC_NONE;
            state_q <= FETCH_RUN;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
            cause_q <= cause_d;
            state_q <= state_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = valid_q;
    assign out_instr   = instr_q;
    assign out_pc      = opc_q;
    assign fault       = state_q == FETCH_FAULT;
    assign fault_cause = cause_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand sequences and a randomized run against a reference model
module tb_fetch_unit;
    localparam int AddrLimit = 512;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, rv = 1'b0, rdy = 1'b0;
    logic [31:0] tgt = '0;
    logic [31:0] imem_addr, imem_rd, out_instr, out_pc;
    logic        out_valid, fault;
    logic [1:0]  fault_cause;
    logic [31:0] mem [0:127];
    int          tests = 0, failed = 0;

    logic        m_valid, m_fault;
    logic [31:0] m_pc, m_pcout, m_instr;
    logic [1:0]  m_cause;

    typedef struct {
        logic        en, rdy, rv;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc, einstr, eaddr;
        logic        ef;
        logic [1:0]  ec;
    } vec_t;
    vec_t vt [15];

    always #5 clk = ~clk;
    assign imem_rd = mem[imem_addr[8:2]];

    fetch_unit dut (
        .clk(clk), .rst(rst), .en(en), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(rv), .redirect_target(tgt), .out_valid(out_valid),
        .out_ready(rdy), .out_instr(out_instr), .out_pc(out_pc),
        .fault(fault), .fault_cause(fault_cause)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic e, logic r, logic v, logic [31:0] t, logic ev,
                                logic [31:0] epc, logic [31:0] ei, logic [31:0] ea,
                                logic ef, logic [1:0] ec);
        vec_t x;
        x.en = e; x.rdy = r; x.rv = v; x.tgt = t; x.ev = ev;
        x.epc = epc; x.einstr = ei; x.eaddr = ea; x.ef = ef; x.ec = ec;
        return x;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_pcout = '0; m_instr = '0; m_fault = 1'b0; m_cause = 2'd0;
    endtask

    // next state straight from the fetch rules: fault freezes, redirect wins, then fetch if free
    task automatic model_step();
        bit free = !m_valid || rdy;
        if (m_fault) m_valid = 1'b0;
        else if (rv) begin
            m_valid = 1'b0;
            if (tgt % 4 != 0) begin m_fault = 1'b1; m_cause = 2'd1; end
            else if (tgt > 32'(AddrLimit - 4)) begin m_fault = 1'b1; m_cause = 2'd2; end
            else m_pc = tgt;
        end else if (en && free) begin
            if (m_pc % 4 != 0) begin m_fault = 1'b1; m_cause = 2'd1; m_valid = 1'b0; end
            else if (m_pc > 32'(AddrLimit - 4)) begin m_fault = 1'b1; m_cause = 2'd2; m_valid = 1'b0; end
            else begin
                m_instr = mem[m_pc / 4]; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, out_valid, m_valid);
        chk({tag, "_fault"}, fault, m_fault);
        chk({tag, "_cause"}, fault_cause, m_cause);
        chk({tag, "_addr"}, imem_addr, m_pc);
        if (m_valid) begin
            chk({tag, "_pc"}, out_pc, m_pcout);
            chk({tag, "_instr"}, out_instr, m_instr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input string tag);
        model_step();
        step();
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_rst_valid"}, out_valid, 1'b0);
        chk({tag, "_rst_fault"}, fault, 1'b0);
        chk({tag, "_rst_cause"}, fault_cause, 2'd0);
        chk({tag, "_rst_addr"}, imem_addr, 32'h0);
        chk({tag, "_rst_pc"}, out_pc, 32'h0);
        chk({tag, "_rst_instr"}, out_instr, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h002081B3; mem[1] = 32'h403202B3; mem[2] = 32'h00308383;
        mem[3] = 32'h0013F333; mem[12] = 32'h00110293;

        vt[0]  = mk(1, 1, 0, 0,     1, 32'h00, 32'h002081B3, 32'h04, 0, 0);
        vt[1]  = mk(1, 1, 0, 0,     1, 32'h04, 32'h403202B3, 32'h08, 0, 0);
        vt[2]  = mk(1, 1, 0, 0,     1, 32'h08, 32'h00308383, 32'h0C, 0, 0);
        vt[3]  = mk(1, 0, 0, 0,     1, 32'h08, 32'h00308383, 32'h0C, 0, 0);
        vt[4]  = mk(1, 0, 0, 0,     1, 32'h08, 32'h00308383, 32'h0C, 0, 0);
        vt[5]  = mk(1, 0, 0, 0,     1, 32'h08, 32'h00308383, 32'h0C, 0, 0);
        vt[6]  = mk(1, 1, 0, 0,     1, 32'h0C, 32'h0013F333, 32'h10, 0, 0);
        vt[7]  = mk(1, 1, 0, 0,     1, 32'h10, 32'hA0000004, 32'h14, 0, 0);
        vt[8]  = mk(1, 1, 0, 0,     1, 32'h14, 32'hA0000005, 32'h18, 0, 0);
        vt[9]  = mk(1, 1, 0, 0,     1, 32'h18, 32'hA0000006, 32'h1C, 0, 0);
        vt[10] = mk(1, 1, 1, 32'h30, 0, 32'h00, 32'h00000000, 32'h30, 0, 0);
        vt[11] = mk(1, 1, 0, 0,     1, 32'h30, 32'h00110293, 32'h34, 0, 0);
        vt[12] = mk(1, 1, 1, 32'h32, 0, 32'h00, 32'h00000000, 32'h34, 1, 1);
        vt[13] = mk(1, 1, 1, 32'h00, 0, 32'h00, 32'h00000000, 32'h34, 1, 1);
        vt[14] = mk(1, 1, 0, 0,     0, 32'h00, 32'h00000000, 32'h34, 1, 1);

        do_reset("init");
        for (int i = 0; i < 15; i++) begin
            en = vt[i].en; rdy = vt[i].rdy; rv = vt[i].rv; tgt = vt[i].tgt;
            step();
            chk($sformatf("v%0d_valid", i), out_valid, vt[i].ev);
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].eaddr);
            chk($sformatf("v%0d_fault", i), fault, vt[i].ef);
            chk($sformatf("v%0d_cause", i), fault_cause, vt[i].ec);
            if (vt[i].ev) begin
                chk($sformatf("v%0d_pc", i), out_pc, vt[i].epc);
                chk($sformatf("v%0d_instr", i), out_instr, vt[i].einstr);
            end
        end
        rv = 1'b0;

        do_reset("in_fault");
        en = 1'b1; rdy = 1'b1;
        tick("restart");
        chk("restart_pc0", out_pc, 32'h0);

        en = 1'b1; rdy = 1'b0;
        tick("hold_a");
        tick("hold_b");
        chk("pre_rst_valid", out_valid, 1'b1);
        do_reset("in_valid");
        rdy = 1'b1;
        tick("restart2");
        chk("restart2_pc0", out_pc, 32'h0);

        do_reset("seq");
        en = 1'b1; rdy = 1'b1; rv = 1'b0;
        for (int i = 0; i < 128; i++) tick("seq");
        chk("last_pc", out_pc, 32'h1FC);
        chk("last_instr", out_instr, 32'hA000007F);
        chk("last_valid", out_valid, 1'b1);
        tick("seq_end");
        chk("range_fault", fault, 1'b1);
        chk("range_cause", fault_cause, 2'd2);
        chk("range_valid", out_valid, 1'b0);

        do_reset("rand");
        for (int i = 0; i < 3000; i++) begin
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) do_reset("rand");
            en  = $urandom_range(0, 7) != 0;
            rdy = $urandom_range(0, 2) != 0;
            rv  = $urandom_range(0, 15) == 0;
            case ($urandom_range(0, 9))
                7:       tgt = 32'($urandom_range(0, 1023)) * 4;
                8:       tgt = (32'($urandom_range(0, 127)) * 4) | 32'($urandom_range(1, 3));
                9:       tgt = $urandom;
                default: tgt = 32'($urandom_range(0, 127)) * 4;
            endcase
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer for the single-cycle RISC-V core. It owns the program counter and drives the address of the combinational instruction memory. It registers each fetched word into a one-entry output stage with a valid/ready handshake toward decode. It also applies branch/jump redirects and traps misaligned or out-of-range fetch addresses in a sticky fault state.

## Interface
- Width, 32, data/address width
- ResetPC, 32'h0000_0000, PC value loaded on reset
- AddrLimit, 512, instruction memory size in bytes; legal fetch addresses are 0 .. AddrLimit-4
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  fetch enable; when 0, PC and output stage hold
- imem_addr  out  Width  byte address to instruction memory, equal to current PC (combinational)
- imem_rd  in  Width  instruction word from memory (combinational read of imem_addr)
- redirect_valid  in  1  branch/jal/jalr taken this cycle
- redirect_target  in  Width  new PC for the redirect
- out_valid  out  1  out_instr/out_pc hold a valid fetched instruction
- out_ready  in  1  decode accepts the output this cycle
- out_instr  out  Width  fetched instruction
- out_pc  out  Width  address of out_instr
- fault  out  1  sticky fetch fault
- fault_cause  out  2  00 none, 01 misaligned target, 10 out of range

## Operation
- States: RUN, FAULT.
- Reset (async): pc=ResetPC, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_cause=00, state=RUN.
- accept = out_valid & out_ready. The output stage is free when !out_valid | accept.
- RUN, redirect_valid=1 (highest priority, regardless of en or stage state):
  - If redirect_target[1:0]!=0: go to FAULT, cause 01.
  - Else if redirect_target > AddrLimit-4: go to FAULT, cause 10.
  - Else: pc=target and out_valid=0. The held instruction is squashed even if it is accepted in the same cycle; decode has consumed it combinationally.
- RUN, no redirect, en=1, stage free:
  - If pc > AddrLimit-4: go to FAULT, cause 10, out_valid=0.
  - Else: out_instr=imem_rd, out_pc=pc, out_valid=1, pc=pc+4. Addition is modulo 2^Width; the range check fires before any wrap.
- RUN, no redirect, stage not free or en=0: all registers hold.
- FAULT: out_valid=0, fault=1, cause held, pc frozen. Redirect and en are ignored. Only reset exits FAULT.
- ResetPC misaligned or out of range: FAULT on the first enabled cycle after reset, using the same checks.

## Timing
- Fetch latency: an instruction at pc appears on out_instr one cycle after the stage is free with en=1.
- Throughput: one instruction per cycle while out_ready=1.
- Redirect penalty: out_valid=0 in the cycle after the redirect; the target instruction is valid one cycle later.
- imem_addr changes only on clock edges or reset; there is no combinational path from out_ready to imem_addr.
- The stall path from out_ready to the register enables is combinational. out_valid, out_instr and out_pc are registered outputs.
- fault and fault_cause assert in the cycle after the offending edge condition.

## Structure
- Shared package `fetch_pkg` holds:
  - the fault_cause encodings FC_NONE/FC_MISALIGN/FC_RANGE;
  - the state enum FETCH_RUN/FETCH_FAULT;
  - the NOP constant 32'h0000_0013.
- Sub-module `fetch_pc_check` is combinational. It takes an address and produces misaligned/out_of_range flags, and is instantiated twice: once for pc, once for redirect_target.
- The instruction memory itself stays outside this block.

## Test plan
- Reset, then en=1, out_ready=1, memory holding 0x002081B3 at 0 and 0x403202B3 at 4 -> out_valid rises one cycle later with out_pc=0/out_instr=0x002081B3, then out_pc=4/out_instr=0x403202B3.
- out_ready=0 for 3 cycles while holding pc 8 (0x00308383) -> out_instr, out_pc and imem_addr=12 stable; one cycle after out_ready returns to 1, pc 12 (0x0013F333) appears.
- Redirect to 0x30 while out_pc=0x18 is held -> next cycle out_valid=0; following cycle out_pc=0x30, out_instr=0x00110293.
- Redirect to 0x32 -> fault=1, fault_cause=01, out_valid=0; a later redirect to 0x0 is ignored.
- Sequential run to pc=0x1FC then 0x200 -> 0x1FC delivered, then fault_cause=10, out_valid=0.
- Assert rst while out_valid=1 and while in FAULT -> immediately out_valid=0, fault=0, imem_addr=0; fetch restarts from 0.
